skinny_inv_sbox8_isw1_pini_ctrl: RTL and testbench

- First-order ISW/PINI masked inverse SKINNY-128 8-bit S-box for the decryption datapath. It is the counterpart of the forward masked sbox8.
- Wraps the eight masked nor-xor gadgets with input/mask capture registers, a latency counter and valid/ready handshakes. Callers therefore do not have to hold shares or masks stable.
- One S-box evaluation is in flight at a time (non-pipelined). The output is held until it is consumed.

---
 rtl/skinny_inv_sbox8_isw1_pini_ctrl.sv | 172 +++++++++++++++++
 tb/tb_skinny_inv_sbox8_isw1_pini_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_inv_sbox8_isw1_pini_ctrl.sv
// First-order ISW/PINI masked inverse SKINNY-128 8-bit S-box with capture registers,
// a latency counter and valid/ready handshakes. One evaluation in flight at a time.
module skinny_inv_sbox8_isw1_pini_ctrl #(
    parameter int LAT       = 8,
    parameter bit CLEAR_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  si1,
    input  logic [7:0]  si0,
    input  logic [15:0] r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  bo1,
    output logic [7:0]  bo0
);

    if (LAT != 8) begin : g_lat_unsupported
        $error("skinny_inv_sbox8_isw1_pini_ctrl: LAT must be 8 (4 gadget levels x 2 stages)");
    end

    localparam int                CNT_W    = $clog2(LAT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         bo0_q, bo0_d, bo1_q, bo1_d;
    logic               capture, busy;

    logic [7:0]         o0_q, o1_q;
    logic [15:0]        r_q;
    // Bit k of each vector belongs to gadget k.
    logic [7:0]         p00_q, p01_q, p10_q, p11_q;
    logic [7:0]         p00_d, p01_d, p10_d, p11_d;
    logic [6:0]         f0_q, f1_q, f0_d, f1_d;
    logic [7:0]         gx0, gx1, gy0, gy1, gz0, gz1;
    logic [7:0]         res0, res1;

    // Returns {p11, p10, p01, p00} of the first gadget stage.
    function automatic logic [3:0] stage1(input logic x0, input logic x1,
                                          input logic y0, input logic y1,
                                          input logic z0, input logic z1,
                                          input logic m0, input logic m1);
        logic xp0, xp1, yp0, yp1;
        xp0 = ~x0;
        xp1 = x1;
        yp0 = ~y0 ^ m0;
        yp1 = y1 ^ m0;
        return {(xp1 & yp1) ^ z1, (xp1 & yp0) ^ m1, (xp0 & yp1) ^ m1, (xp0 & yp0) ^ z0};
    endfunction

    // Later levels take b shares from stage-2 registers: f[0]=b2 f[1]=b3 f[2]=b7 f[3]=b5 f[4]=b1 f[5]=b0 f[6]=b6.
    assign gx0 = {f0_q[2], f0_q[0], f0_q[1], o0_q[5], o0_q[6], o0_q[2], o0_q[7], o0_q[3]};
    assign gx1 = {f1_q[2], f1_q[0], f1_q[1], o1_q[5], o1_q[6], o1_q[2], o1_q[7], o1_q[3]};
    assign gy0 = {f0_q[6], f0_q[4], f0_q[0], f0_q[1], o0_q[5], o0_q[7], o0_q[6], o0_q[1]};
    assign gy1 = {f1_q[6], f1_q[4], f1_q[0], f1_q[1], o1_q[5], o1_q[7], o1_q[6], o1_q[1]};
    assign gz0 = {o0_q[6], o0_q[2], o0_q[5], o0_q[3], o0_q[7], o0_q[1], o0_q[4], o0_q[0]};
    assign gz1 = {o1_q[6], o1_q[2], o1_q[5], o1_q[3], o1_q[7], o1_q[1], o1_q[4], o1_q[0]};

    always_comb begin
        p00_d = '0;
        p01_d = '0;
        p10_d = '0;
        p11_d = '0;
        for (int k = 0; k < 8; k++) begin
            {p11_d[k], p10_d[k], p01_d[k], p00_d[k]} =
                stage1(gx0[k], gx1[k], gy0[k], gy1[k], gz0[k], gz1[k], r_q[2*k], r_q[2*k+1]);
        end
    end

    assign f0_d = p00_q[6:0] ^ p01_q[6:0];
    assign f1_d = p10_q[6:0] ^ p11_q[6:0];

    // The last gadget's second stage is the output register itself.
    assign res0 = {f0_q[2], f0_q[6], f0_q[3], p00_q[7] ^ p01_q[7], f0_q[1], f0_q[0], f0_q[4], f0_q[5]};
    assign res1 = {f1_q[2], f1_q[6], f1_q[3], p10_q[7] ^ p11_q[7], f1_q[1], f1_q[0], f1_q[4], f1_q[5]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        bo0_d       = bo0_q;
        bo1_d       = bo1_q;
        capture     = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_valid_d = 1'b1;
                    bo0_d       = res0;
                    bo1_d       = res1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (CLEAR_OUT) begin
                        bo0_d = '0;
                        bo1_d = '0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o0_q        <= '0;
            o1_q        <= '0;
            r_q         <= '0;
            p00_q       <= '0;
            p01_q       <= '0;
            p10_q       <= '0;
            p11_q       <= '0;
            f0_q        <= '0;
            f1_q        <= '0;
            out_valid_q <= 1'b0;
            bo0_q       <= '0;
            bo1_q       <= '0;
        end else begin
            if (capture) begin
                o0_q <= si0;
                o1_q <= si1;
                r_q  <= r;
            end
            if (busy) begin
                p00_q <= p00_d;
                p01_q <= p01_d;
                p10_q <= p10_d;
                p11_q <= p11_d;
                f0_q  <= f0_d;
                f1_q  <= f1_d;
            end
            out_valid_q <= out_valid_d;
            bo0_q       <= bo0_d;
            bo1_q       <= bo1_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bo0       = bo0_q;
    assign bo1       = bo1_q;

endmodule

// File: tb/tb_skinny_inv_sbox8_isw1_pini_ctrl.sv
// Randomized self-checking bench for the masked inverse SKINNY-128 S-box controller,
// compared against an unmasked reference of the inverse network.
module tb_skinny_inv_sbox8_isw1_pini_ctrl;

    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  si1, si0;
    logic [15:0] r;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  bo1, bo0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fwd [256];
    logic [7:0] anchor [16];

    always #5 clk = ~clk;

    skinny_inv_sbox8_isw1_pini_ctrl #(.LAT(LAT), .CLEAR_OUT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .si1       (si1),
        .si0       (si0),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bo1       (bo1),
        .bo0       (bo0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic nx(input logic a, input logic b, input logic c);
        return ~(a | b) ^ c;
    endfunction

    // Unmasked inverse S-box: the NOR-XOR network on plain bits.
    function automatic logic [7:0] inv_ref(input logic [7:0] o);
        logic [7:0] b;
        b[2] = nx(o[3], o[1], o[0]);
        b[3] = nx(o[7], o[6], o[4]);
        b[7] = nx(o[2], o[7], o[1]);
        b[5] = nx(o[6], o[5], o[7]);
        b[1] = nx(o[5], b[3], o[3]);
        b[0] = nx(b[3], b[2], o[5]);
        b[6] = nx(b[2], b[1], o[2]);
        b[4] = nx(b[7], b[6], o[6]);
        return b;
    endfunction

    // Accept one operation and wait for its result; leaves the result pending.
    task automatic issue(input logic [7:0] s1, input logic [7:0] s0, input logic [15:0] rr,
                         input logic [7:0] exp, input string tag);
        int waited;
        int lat;
        in_valid = 1'b1;
        si1 = s1;
        si0 = s0;
        r   = rr;
        waited = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        check($sformatf("%s/accept", tag), in_ready, 1);
        step();
        in_valid = 1'b0;
        si1 = 8'($urandom);
        si0 = 8'($urandom);
        r   = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check($sformatf("%s/latency", tag), lat, LAT);
        check($sformatf("%s/result", tag), bo1 ^ bo0, exp);
    endtask

    task automatic consume(input string tag);
        logic [7:0] h0, h1;
        h0 = bo0;
        h1 = bo1;
        repeat ($urandom_range(0, 2)) begin
            step();
            check($sformatf("%s/hold", tag), {out_valid, bo1, bo0}, {1'b1, h1, h0});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check($sformatf("%s/drop", tag), out_valid, 0);
        check($sformatf("%s/clear", tag), {bo1, bo0}, 16'h0);
        check($sformatf("%s/ready", tag), in_ready, 1);
    endtask

    task automatic run_op(input logic [7:0] s1, input logic [7:0] s0, input logic [15:0] rr,
                          input logic [7:0] exp, input string tag);
        issue(s1, s0, rr, exp, tag);
        consume(tag);
    endtask

    initial begin
        logic [7:0] s1, x, h0, h1;
        int lat;
        int seen_valid;

        anchor = '{8'h65, 8'h4c, 8'h6a, 8'h42, 8'h4b, 8'h63, 8'h43, 8'h6b,
                   8'h55, 8'h75, 8'h5a, 8'h7a, 8'h53, 8'h73, 8'h5b, 8'h7b};
        for (int i = 0; i < 256; i++) fwd[inv_ref(8'(i))] = 8'(i);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        si1 = 8'h0;
        si0 = 8'h0;
        r = 16'h0;
        repeat (3) step();
        check("reset/state", {in_ready, out_valid, bo1, bo0}, {1'b1, 1'b0, 16'h0});
        rst = 1'b0;
        step();

        run_op(8'h00, 8'h65, 16'h0000, 8'h00, "zero");
        issue(8'hA5, 8'hE9, 16'hBEEF, 8'h01, "masked");
        check("masked/sh1_hidden", bo1 != 8'h01, 1);
        check("masked/sh0_hidden", bo0 != 8'h01, 1);
        consume("masked");
        run_op(8'h3C, 8'hC3, 16'($urandom), 8'hFF, "ff");

        for (int i = 0; i < 16; i++) begin
            s1 = 8'($urandom);
            run_op(s1, s1 ^ anchor[i], 16'($urandom), 8'(i), $sformatf("anchor%0d", i));
        end

        // Stall: pending result must freeze while new requests are offered.
        s1 = 8'($urandom);
        issue(s1, s1 ^ 8'h65, 16'($urandom), 8'h00, "stall1");
        h0 = bo0;
        h1 = bo1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            si1 = 8'($urandom);
            si0 = 8'($urandom);
            r   = 16'($urandom);
            step();
            check("stall/hold", {in_ready, out_valid, bo1, bo0}, {1'b0, 1'b1, h1, h0});
        end
        x = 8'($urandom);
        s1 = 8'($urandom);
        si1 = s1;
        si0 = s1 ^ fwd[x];
        r = 16'($urandom);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("stall/consumed", {in_ready, out_valid}, 2'b10);
        step();
        in_valid = 1'b0;
        si1 = 8'($urandom);
        si0 = 8'($urandom);
        check("stall/captured_late", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("stall/latency", lat, LAT);
        check("stall/result", bo1 ^ bo0, x);
        consume("stall2");

        // Reset in the middle of BUSY discards the operation.
        s1 = 8'($urandom);
        in_valid = 1'b1;
        si1 = s1;
        si0 = s1 ^ 8'h65;
        r = 16'($urandom);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_busy/state", {in_ready, out_valid, bo1, bo0}, {1'b1, 1'b0, 16'h0});
        seen_valid = 0;
        repeat (12) begin
            step();
            if (out_valid) seen_valid++;
        end
        check("rst_busy/discarded", seen_valid, 0);
        s1 = 8'($urandom);
        run_op(s1, s1 ^ 8'h65, 16'($urandom), 8'h00, "after_rst");

        // Reset while a nonzero result is pending.
        s1 = 8'($urandom);
        issue(s1, s1 ^ 8'h4c, 16'($urandom), 8'h01, "rst_done");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_done/state", {in_ready, out_valid, bo1, bo0}, {1'b1, 1'b0, 16'h0});

        for (int i = 0; i < 256; i++) begin
            s1 = 8'($urandom);
            run_op(s1, s1 ^ fwd[i], 16'($urandom), 8'(i), $sformatf("exh%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
